pc_gen: RTL



---
 rtl/pc_gen_pkg.sv | 19 +
 rtl/pc_redirect_arb.sv | 23 ++
 rtl/pc_gen.sv | 100 ++++++++++
 3 files changed

// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch-PC generator: default address width,
// reset address, FSM state encodings and the alignment-check helper.
package pc_gen_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam logic [63:0] PC_RESET_ADDR = 64'h8000_0000;

  localparam logic [1:0] PCG_BOOT = 2'd0;
  localparam logic [1:0] PCG_RUN  = 2'd1;
  localparam logic [1:0] PCG_HALT = 2'd2;

  // Only bit 0 matters with compressed instructions; otherwise bits [1:0].
  function automatic logic is_misaligned(input logic [1:0] low_bits, input int ialign);
    if (ialign == 16)
      return low_bits[0];
    return |low_bits;
  endfunction

endpackage

// File: rtl/pc_redirect_arb.sv
// Fixed-priority redirect arbiter: the lowest-index valid channel supplies
// the target; purely combinational.
module pc_redirect_arb #(
  parameter int XLEN = 64,
  parameter int NUM  = 3
) (
  input  logic [NUM-1:0]      valid,
  input  logic [NUM*XLEN-1:0] targets,
  output logic                any_valid,
  output logic [XLEN-1:0]     target
);

  // Walking from the highest index down lets lower channels overwrite.
  always_comb begin
    any_valid = |valid;
    target    = '0;
    for (int k = NUM - 1; k >= 0; k--) begin
      if (valid[k])
        target = targets[k*XLEN +: XLEN];
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Fetch-PC generator: boots from RESET_VAL, steps by fetch block, takes
// prioritised redirects (bumping the epoch) and supports halt/resume.
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              XLEN         = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_VAL    = XLEN'(PC_RESET_ADDR),
  parameter int              NUM_REDIRECT = 3,
  parameter int              FETCH_BYTES  = 4,
  parameter int              IALIGN       = 32,
  parameter int              EPOCH_W      = 3
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REDIRECT-1:0]      redirect_valid_i,
  input  logic [NUM_REDIRECT*XLEN-1:0] redirect_pc_i,
  input  logic                         halt_req_i,
  input  logic                         resume_i,
  input  logic                         pc_ready_i,
  output logic                         pc_valid_o,
  output logic [XLEN-1:0]              pc_o,
  output logic [EPOCH_W-1:0]           pc_epoch_o,
  output logic                         pc_misalign_o,
  output logic                         halted_o
);

  localparam logic [XLEN-1:0] STEP       = XLEN'(FETCH_BYTES);
  localparam logic [XLEN-1:0] BLOCK_MASK = ~(STEP - XLEN'(1));

  logic [1:0]         state_q, state_d;
  logic [XLEN-1:0]    pc_q, pc_d;
  logic [EPOCH_W-1:0] epoch_q, epoch_d;
  logic               misalign_q, misalign_d;

  logic               redir_any;
  logic [XLEN-1:0]    redir_target;
  logic               take_redirect;
  logic               accept;

  pc_redirect_arb #(
    .XLEN (XLEN),
    .NUM  (NUM_REDIRECT)
  ) u_arb (
    .valid     (redirect_valid_i),
    .targets   (redirect_pc_i),
    .any_valid (redir_any),
    .target    (redir_target)
  );

  assign pc_valid_o    = (state_q == PCG_RUN);
  assign halted_o      = (state_q == PCG_HALT);
  assign pc_o          = pc_q;
  assign pc_epoch_o    = epoch_q;
  assign pc_misalign_o = misalign_q;

  // The boot bubble keeps the reset PC, so redirects are ignored there.
  assign take_redirect = redir_any && (state_q != PCG_BOOT);
  assign accept        = pc_valid_o && pc_ready_i;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      PCG_BOOT: state_d = PCG_RUN;
      PCG_RUN:  if (!redir_any && halt_req_i) state_d = PCG_HALT;
      PCG_HALT: if (redir_any || resume_i) state_d = PCG_RUN;
      default:  state_d = PCG_BOOT;
    endcase
  end

  // A redirect beats the sequential step even when IF accepted this cycle:
  // IF keeps the old PC/epoch, and the register moves to the new target.
  always_comb begin
    pc_d       = pc_q;
    epoch_d    = epoch_q;
    misalign_d = misalign_q;
    if (take_redirect) begin
      pc_d       = redir_target;
      epoch_d    = epoch_q + EPOCH_W'(1);
      misalign_d = is_misaligned(redir_target[1:0], IALIGN);
    end else if (accept) begin
      pc_d       = (pc_q & BLOCK_MASK) + STEP;
      misalign_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PCG_BOOT;
      pc_q       <= RESET_VAL;
      epoch_q    <= '0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      epoch_q    <= epoch_d;
      misalign_q <= misalign_d;
    end
  end

endmodule
